// File: rtl/uart_tx_if.sv
// Host-side bus of the UART transmitter: write strobe, byte, serial line and status.
// The master modport is the host/bench side; the slave modport is the transmitter.
interface uart_tx_if;
    logic       write;
    logic [7:0] tdata;
    logic       tx;
    logic       txrdy;
    logic       txbusy;

    modport master (output write, output tdata, input tx, input txrdy, input txbusy);
    modport slave  (input write, input tdata, output tx, output txrdy, output txbusy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: THR plus shifter, frame = start, 8 data LSB first, parity, stop, 16 clocks per bit.
// Start bit begins one clock after the accept edge; a write arriving while the THR is full is dropped.
module uart_tx #(
    parameter logic PARITY_MODE = 1'b1
) (
    input  logic       mclkx16,
    input  logic       reset,
    uart_tx_if.slave   bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state;
    logic [3:0] phase;
    logic [2:0] bit_idx;
    logic [7:0] thr;
    logic [7:0] shift;
    logic       par;
    logic       write_d;
    logic       tx;
    logic       txrdy;
    logic       txbusy;
    logic       accept;

    assign accept     = bus.write && !write_d;
    assign bus.tx     = tx;
    assign bus.txrdy  = txrdy;
    assign bus.txbusy = txbusy;

    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 4'd0;
            bit_idx <= 3'd0;
            thr     <= 8'h00;
            shift   <= 8'h00;
            par     <= 1'b0;
            write_d <= 1'b1;
            tx      <= 1'b1;
            txrdy   <= 1'b1;
            txbusy  <= 1'b0;
        end else begin
            write_d <= bus.write;

            // txrdy low means the THR holds a byte waiting for the shifter
            if (state == IDLE) begin
                if (!txrdy) begin
                    state  <= START;
                    shift  <= thr;
                    par    <= PARITY_MODE ^ (^thr);
                    tx     <= 1'b0;
                    txbusy <= 1'b1;
                    txrdy  <= 1'b1;
                    phase  <= 4'd0;
                end
            end else begin
                phase <= phase + 4'd1;
                if (phase == 4'd15) begin
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                            tx      <= shift[0];
                        end
                        DATA: begin
                            if (bit_idx == 3'd7) begin
                                state <= PARITY;
                                tx    <= par;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shift   <= {1'b0, shift[7:1]};
                                tx      <= shift[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                        STOP: begin
                            // a queued byte starts immediately, no idle gap between frames
                            if (!txrdy) begin
                                state <= START;
                                shift <= thr;
                                par   <= PARITY_MODE ^ (^thr);
                                tx    <= 1'b0;
                                txrdy <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                tx     <= 1'b1;
                                txbusy <= 1'b0;
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            tx     <= 1'b1;
                            txbusy <= 1'b0;
                        end
                    endcase
                end
            end

            // uses the registered txrdy, so a write coinciding with a transfer is dropped
            if (accept && txrdy) begin
                thr   <= bus.tdata;
                txrdy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, latency, back-to-back, overflow, parity sense, reset mid-frame.
module tb_uart_tx;
    logic mclkx16 = 1'b0;
    logic reset   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   sel      = 1'b0;
    logic mon_tx;

    uart_tx_if bus0();
    uart_tx_if bus1();

    uart_tx #(.PARITY_MODE(1'b1)) dut0 (.mclkx16(mclkx16), .reset(reset), .bus(bus0));
    uart_tx #(.PARITY_MODE(1'b0)) dut1 (.mclkx16(mclkx16), .reset(reset), .bus(bus1));

    assign mon_tx = sel ? bus1.tx : bus0.tx;

    always #5 mclkx16 = ~mclkx16;
    always @(posedge mclkx16) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] b, input logic m);
        return {1'b1, m ^ (^b), b, 1'b0};
    endfunction

    task automatic do_write(input logic [7:0] b);
        @(negedge mclkx16);
        if (sel) begin bus1.tdata = b; bus1.write = 1'b0; end
        else     begin bus0.tdata = b; bus0.write = 1'b0; end
        @(negedge mclkx16);
        if (sel) bus1.write = 1'b1;
        else     bus0.write = 1'b1;
    endtask

    // Samples each bit at its midpoint; t0 is the cycle count at the first low sample.
    task automatic capture(output logic [10:0] bits, output int t0, output bit ok);
        int n = 0;
        ok = 1'b1; bits = '1; t0 = 0;
        while (mon_tx !== 1'b0 && n < 600) begin
            @(negedge mclkx16);
            n++;
        end
        if (mon_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t0 = cyc;
        for (int b = 0; b < 11; b++) begin
            repeat ((b == 0) ? 8 : 16) @(negedge mclkx16);
            bits[b] = mon_tx;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge mclkx16);
        checks++; if (bus0.tx !== 1'b1)     begin failures++; $display("FAIL reset_tx got=%b want=1", bus0.tx); end
        checks++; if (bus0.txrdy !== 1'b1)  begin failures++; $display("FAIL reset_txrdy got=%b want=1", bus0.txrdy); end
        checks++; if (bus0.txbusy !== 1'b0) begin failures++; $display("FAIL reset_txbusy got=%b want=0", bus0.txbusy); end
        checks++; if (bus1.tx !== 1'b1)     begin failures++; $display("FAIL reset_tx_even got=%b want=1", bus1.tx); end
        reset = 1'b0;
        repeat (2) @(negedge mclkx16);
    endtask

    task automatic test_single;
        logic [10:0] bits = '1;
        int k = 0;
        sel = 1'b0;
        do_write(8'h55);
        @(negedge mclkx16);  // just after the accept edge
        checks++; if (bus0.txrdy !== 1'b0) begin failures++; $display("FAIL single_txrdy_after_accept got=%b want=0", bus0.txrdy); end
        checks++; if (bus0.tx !== 1'b1)    begin failures++; $display("FAIL single_tx_before_start got=%b want=1", bus0.tx); end
        @(negedge mclkx16);  // just after the transfer edge
        checks++; if (bus0.tx !== 1'b0)     begin failures++; $display("FAIL single_start_bit got=%b want=0", bus0.tx); end
        checks++; if (bus0.txrdy !== 1'b1)  begin failures++; $display("FAIL single_txrdy_return got=%b want=1", bus0.txrdy); end
        checks++; if (bus0.txbusy !== 1'b1) begin failures++; $display("FAIL single_txbusy_rise got=%b want=1", bus0.txbusy); end
        while (bus0.txbusy === 1'b1 && k < 400) begin
            if (k % 16 == 8) bits[k / 16] = bus0.tx;
            k++;
            @(negedge mclkx16);
        end
        checks++; if (bits !== 11'b11010101010) begin failures++; $display("FAIL single_frame_55 got=%b want=%b", bits, 11'b11010101010); end
        checks++; if (k != 176) begin failures++; $display("FAIL single_busy_len got=%0d want=176", k); end
        checks++; if (bus0.tx !== 1'b1) begin failures++; $display("FAIL single_idle_tx got=%b want=1", bus0.tx); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] f1, f2;
        int t1, t2;
        bit ok1, ok2;
        logic rdy_after;
        sel = 1'b0;
        rdy_after = 1'b1;
        do_write(8'hA5);
        fork
            begin
                capture(f1, t1, ok1);
                capture(f2, t2, ok2);
            end
            begin
                repeat (60) @(negedge mclkx16);
                do_write(8'h3C);
                @(negedge mclkx16);
                rdy_after = bus0.txrdy;
            end
        join
        checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL b2b_txrdy_queued got=%b want=0", rdy_after); end
        checks++; if (!ok1 || f1 !== exp_frame(8'hA5, 1'b1)) begin failures++; $display("FAIL b2b_frame_a5 got=%b want=%b", f1, exp_frame(8'hA5, 1'b1)); end
        checks++; if (!ok2 || f2 !== exp_frame(8'h3C, 1'b1)) begin failures++; $display("FAIL b2b_frame_3c got=%b want=%b", f2, exp_frame(8'h3C, 1'b1)); end
        checks++; if (f1[9] !== 1'b1 || f2[9] !== 1'b1) begin failures++; $display("FAIL b2b_parity got=%b%b want=11", f1[9], f2[9]); end
        checks++; if (t2 - t1 != 176) begin failures++; $display("FAIL b2b_start_spacing got=%0d want=176", t2 - t1); end
        checks++; if (bus0.txrdy !== 1'b1) begin failures++; $display("FAIL b2b_txrdy_end got=%b want=1", bus0.txrdy); end
        repeat (20) @(negedge mclkx16);
    endtask

    task automatic test_overflow;
        logic [10:0] f1, f2;
        int t1, t2, lows;
        bit ok1, ok2;
        sel = 1'b0;
        lows = 0;
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        capture(f1, t1, ok1);
        capture(f2, t2, ok2);
        checks++; if (!ok1 || f1 !== exp_frame(8'h11, 1'b1)) begin failures++; $display("FAIL ovf_frame_11 got=%b want=%b", f1, exp_frame(8'h11, 1'b1)); end
        checks++; if (!ok2 || f2 !== exp_frame(8'h22, 1'b1)) begin failures++; $display("FAIL ovf_frame_22 got=%b want=%b", f2, exp_frame(8'h22, 1'b1)); end
        repeat (250) begin
            @(negedge mclkx16);
            if (bus0.tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL ovf_dropped_33 low_cycles=%0d want=0", lows); end
        checks++; if (bus0.txbusy !== 1'b0 || bus0.txrdy !== 1'b1) begin failures++; $display("FAIL ovf_idle busy=%b rdy=%b want busy=0 rdy=1", bus0.txbusy, bus0.txrdy); end
    endtask

    task automatic test_parity_even;
        logic [10:0] f;
        int t;
        bit ok;
        sel = 1'b1;
        do_write(8'h01);
        capture(f, t, ok);
        checks++; if (!ok || f !== 11'b11000000010) begin failures++; $display("FAIL even_frame_01 got=%b want=%b", f, 11'b11000000010); end
        checks++; if (f[9] !== 1'b1) begin failures++; $display("FAIL even_parity_01 got=%b want=1", f[9]); end
        repeat (20) @(negedge mclkx16);
        do_write(8'h03);
        capture(f, t, ok);
        checks++; if (!ok || f !== 11'b10000000110) begin failures++; $display("FAIL even_frame_03 got=%b want=%b", f, 11'b10000000110); end
        checks++; if (f[9] !== 1'b0) begin failures++; $display("FAIL even_parity_03 got=%b want=0", f[9]); end
        repeat (20) @(negedge mclkx16);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] f;
        int t, n, lows;
        bit ok;
        sel = 1'b0;
        n = 0; lows = 0;
        do_write(8'hFF);
        while (bus0.tx !== 1'b0 && n < 50) begin @(negedge mclkx16); n++; end
        checks++; if (bus0.tx !== 1'b0) begin failures++; $display("FAIL rst_mid_start got=%b want=0", bus0.tx); end
        repeat (20) @(negedge mclkx16);
        do_write(8'h5A);
        @(negedge mclkx16);
        checks++; if (bus0.txrdy !== 1'b0) begin failures++; $display("FAIL rst_mid_queued got=%b want=0", bus0.txrdy); end
        repeat (47) @(negedge mclkx16);  // mid DATA(3)
        checks++; if (bus0.tx !== 1'b1 || bus0.txbusy !== 1'b1) begin failures++; $display("FAIL rst_mid_inframe tx=%b busy=%b want tx=1 busy=1", bus0.tx, bus0.txbusy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus0.tx !== 1'b1 || bus0.txrdy !== 1'b1 || bus0.txbusy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async tx=%b rdy=%b busy=%b want 1 1 0", bus0.tx, bus0.txrdy, bus0.txbusy);
        end
        @(negedge mclkx16);
        reset = 1'b0;
        repeat (300) begin
            @(negedge mclkx16);
            if (bus0.tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL rst_mid_thr_discard low_cycles=%0d want=0", lows); end
        do_write(8'h80);
        capture(f, t, ok);
        checks++; if (!ok || f !== exp_frame(8'h80, 1'b1)) begin failures++; $display("FAIL rst_mid_frame_80 got=%b want=%b", f, exp_frame(8'h80, 1'b1)); end
        repeat (20) @(negedge mclkx16);
    endtask

    task automatic test_byte_sweep;
        logic [7:0] vals [6];
        logic [10:0] f;
        int t;
        bit ok;
        sel = 1'b0;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        for (int i = 2; i < 6; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            do_write(vals[i]);
            capture(f, t, ok);
            checks++;
            if (!ok || f[8:1] !== vals[i] || f[0] !== 1'b0 || f[10] !== 1'b1 || (^f[9:1]) !== 1'b1) begin
                failures++; $display("FAIL sweep_byte_%02h got=%b want=%b", vals[i], f, exp_frame(vals[i], 1'b1));
            end
            repeat (10) @(negedge mclkx16);
        end
    endtask

    initial begin
        bus0.write = 1'b1; bus0.tdata = 8'h00;
        bus1.write = 1'b1; bus1.tdata = 8'h00;
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_parity_even;
        test_reset_mid_frame;
        test_byte_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
